// File: rtl/serial_output_if.sv
// Word handshake between an application source (master) and serial_output (slave).
interface serial_output_if;
  logic [31:0] rs232_tx;
  logic        rs232_tx_stb;
  logic        rs232_tx_ack;

  modport master (output rs232_tx, output rs232_tx_stb, input rs232_tx_ack);
  modport slave  (input rs232_tx, input rs232_tx_stb, output rs232_tx_ack);
endinterface

// File: rtl/serial_output.sv
// UART transmitter fed by a small word FIFO through a stb/ack handshake.
// Define SERIAL_OUTPUT_PARITY_EN to add an even parity bit (11-bit frames).
//
// state  | meaning
// IDLE   | line high; pop FIFO head into shift register when available
// START  | start bit, line low for one bit period
// DATA   | eight data bits, LSB first, one bit period each
// PARITY | even parity over the data bits (SERIAL_OUTPUT_PARITY_EN only)
// STOP   | stop bit, line high for one bit period
module serial_output #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_output_if.slave bus,
  output logic           tx,
  output logic           busy
);

  localparam int T  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(T - 1);

`ifdef SERIAL_OUTPUT_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          r_ack;
  logic          r_rdy;
  logic          r_tx;
  logic          r_busy;
  logic          w_tx;
  logic          w_pop;
  logic          w_push;
  logic          w_tick;
  logic          w_empty;
  logic          w_full;
  logic          w_unused_upper;
`ifdef SERIAL_OUTPUT_PARITY_EN
  logic          r_parity;
`endif

  assign w_unused_upper = ^bus.rs232_tx[31:8];

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = bus.rs232_tx_stb && r_ack;
  assign w_tick  = (r_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
`ifdef SERIAL_OUTPUT_PARITY_EN
      S_DATA:   if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = S_PARITY;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`else
      S_DATA:   if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
`endif
      S_STOP:   if (w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_tx  = 1'b1;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:   w_pop = !w_empty;
      S_START:  w_tx  = 1'b0;
      S_DATA:   w_tx  = r_shift[0];
`ifdef SERIAL_OUTPUT_PARITY_EN
      S_PARITY: w_tx  = r_parity;
`endif
      default:  w_tx  = 1'b1;
    endcase
  end

  // Storage has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.rs232_tx[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // r_rdy keeps the first ack off the first edge after reset release;
  // ack is a one-cycle pulse so a held strobe can't double-transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy  <= 1'b0;
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_tx   <= 1'b1;
    end else begin
      r_rdy  <= 1'b1;
      r_ack  <= r_rdy && !r_ack && bus.rs232_tx_stb && !w_full;
      r_busy <= !w_empty || (r_state != S_IDLE);
      r_tx   <= w_tx;
    end
  end

  // Bit timer, shift register and bit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef SERIAL_OUTPUT_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_pop) begin
      r_cnt     <= RELOAD;
      r_shift   <= r_mem[r_rptr[AW-1:0]];
      r_bit_idx <= '0;
`ifdef SERIAL_OUTPUT_PARITY_EN
      r_parity  <= ^r_mem[r_rptr[AW-1:0]];
`endif
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_cnt <= RELOAD;
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign tx               = r_tx;
  assign busy             = r_busy;
  assign bus.rs232_tx_ack = r_ack;

endmodule

// File: tb/tb_serial_output.sv
// Scoreboard bench for serial_output: a UART line decoder checks each frame
// against characters queued at transfer time; directed plus $urandom stimulus.
`timescale 1ns/1ps
module tb_serial_output;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int T      = CLK_HZ / BAUD;
`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam int FRAME  = NBITS * T;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [7:0] q_exp [$];
  int   q_fall [$];

  serial_output_if bus ();

  serial_output #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int fall_at(input int i);
    return (i < q_fall.size()) ? q_fall[i] : -1000000;
  endfunction

  // Offer one word and hold it until acknowledged; returns the transfer cycle.
  task automatic send(input logic [31:0] word, output int t_xfer);
    int n;
    n = 0;
    t_xfer = -1;
    bus.rs232_tx     = word;
    bus.rs232_tx_stb = 1'b1;
    while (n <= 4000) begin
      @(negedge clk);
      if (bus.rs232_tx_ack) break;
      n++;
    end
    if (n > 4000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h never acknowledged", word);
      bus.rs232_tx_stb = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      t_xfer = cyc;
      q_exp.push_back(word[7:0]);
      bus.rs232_tx_stb = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q_exp.size() != 0 && n < 20 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d characters never seen on the line", q_exp.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Line decoder: every bit must hold for exactly T samples.
  initial begin : rx_mon
    logic prev;
    logic v;
    logic stable;
    logic abort;
    logic [NBITS-1:0] bits;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev && !tx) begin
        q_fall.push_back(cyc);
        abort  = 1'b0;
        stable = 1'b1;
        bits   = '0;
        for (int b = 0; b < NBITS; b++) begin
          v = tx;
          for (int s = 0; s < T; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (!rst) begin
              abort = 1'b1;
              break;
            end
            if (s == 0) v = tx;
            else if (tx !== v) stable = 1'b0;
          end
          if (abort) break;
          bits[b] = v;
        end
        if (!abort) begin
          if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: frame with data %0h but nothing expected", bits[8:1]);
          end else begin
            e = q_exp.pop_front();
            check("rx_data", {24'd0, bits[8:1]}, {24'd0, e});
            check("rx_stop", {31'd0, bits[NBITS-1]}, 32'd1);
            check("rx_bit_width", {31'd0, stable}, 32'd1);
`ifdef SERIAL_OUTPUT_PARITY_EN
            check("rx_parity", {31'd0, bits[9]}, 32'($countones(e) % 2));
`endif
          end
        end
      end
      prev = tx;
    end
  end

  initial begin : ack_mon
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rs232_tx_ack) begin
        check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
        check("ack_needs_stb", {31'd0, bus.rs232_tx_stb}, 32'd1);
      end
      prev_ack = bus.rs232_tx_ack;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int tx6 [6];
    int n;
    int gap;
    bus.rs232_tx     = '0;
    bus.rs232_tx_stb = 1'b0;

    // Reset values, then first ack held off past the first edge.
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ack", {31'd0, bus.rs232_tx_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    bus.rs232_tx     = 32'h0000_0055;
    bus.rs232_tx_stb = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 check("ack_after_first_edge", {31'd0, bus.rs232_tx_ack}, 32'd0);

    // Single word 0x55
    q_fall.delete();
    send(32'h0000_0055, t);
    repeat (5) @(negedge clk);
    check("busy_during_frame", {31'd0, busy}, 32'd1);
    drain();
    check("latency_tx_fall", 32'(fall_at(0) - t), 32'd2);
    check("busy_after_frame", {31'd0, busy}, 32'd0);

    // Six back-to-back words overrun the 4-deep FIFO by one.
    q_fall.delete();
    for (int i = 0; i < 6; i++) send(32'h41 + 32'(i), tx6[i]);
    drain();
    check("b2b_latency", 32'(fall_at(0) - tx6[0]), 32'd2);
    check("b2b_fill_rate", 32'(tx6[4] - tx6[0]), 32'd8);
    check("b2b_sixth_ack_after_pop", 32'(tx6[5] - fall_at(1)), 32'd1);
    for (int i = 1; i < 6; i++)
      check("b2b_frame_spacing", 32'(fall_at(i) - fall_at(i - 1)), 32'(FRAME + 1));
    check("b2b_frame_count", 32'(q_fall.size()), 32'd6);

    // Upper bits ignored
    send(32'hFFFF_FF00, t);
    drain();

    // Parity-sensitive characters and frame length
    q_fall.delete();
    send(32'h07, t);
    send(32'h03, t);
    drain();
    check("frame_length", 32'(fall_at(1) - fall_at(0)), 32'(FRAME + 1));

    // Random words with random spacing
    for (int i = 0; i < 12; i++) begin
      send($urandom, t);
      gap = $urandom_range(0, 2 * FRAME);
      repeat (gap) @(negedge clk);
    end
    drain();
    check("busy_after_random", {31'd0, busy}, 32'd0);

    // Reset during DATA bit 3 of 0xA5 with two words queued
    q_fall.delete();
    send(32'hA5, t);
    send(32'h11, t);
    send(32'h22, t);
    n = 0;
    while (cyc < fall_at(0) + 4 * T + T / 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reset_setup_timeout", 32'(n < 1000), 32'd1);
    @(posedge clk);
    #2 check("pre_reset_bit3_low", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx}, 32'd1);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    q_exp.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    q_fall.delete();
    repeat (3) @(negedge clk);
    check("busy_after_release", {31'd0, busy}, 32'd0);
    repeat (3 * FRAME) @(negedge clk);
    check("nothing_after_reset", 32'(q_fall.size()), 32'd0);
    check("idle_line_after_reset", {31'd0, tx}, 32'd1);
    send(32'h3C, t);
    drain();
    check("new_word_after_reset", 32'(q_fall.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
